// File: rtl/stream_demux_1x2_pkg.sv
// rtl/stream_demux_1x2_pkg.sv - shared constants for the 1-to-2 stream demux
package stream_demux_1x2_pkg;

    localparam int DEMUX_DEPTH = 2;
    localparam int LEVEL_W     = 2;

    localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = 2'd0;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL  = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_demux_1x2_fifo2.sv
// rtl/stream_demux_1x2_fifo2.sv - two-entry per-port FIFO with explicit level
module demux_fifo2
    import stream_demux_1x2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   r_mem [DEMUX_DEPTH];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;

    logic w_push_ok;
    logic w_pop_ok;

    // A full FIFO refuses writes even when it is popped on the same edge.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEMUX_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_level  <= LEVEL_EMPTY;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_level == LEVEL_FULL);
    assign empty = (r_level == LEVEL_EMPTY);
    assign level = r_level;

endmodule

// File: rtl/stream_demux_1x2.sv
// rtl/stream_demux_1x2.sv - routes one input stream to port A or B via per-port FIFOs
module stream_demux_1x2
    import stream_demux_1x2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [WIDTH-1:0]   b_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [LEVEL_W-1:0] a_level,
    output logic [LEVEL_W-1:0] b_level
);

    logic w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic w_accept, w_a_push, w_b_push, w_a_pop, w_b_pop;

    // Ready depends only on in_sel and registered FIFO state; rst_n forces it low during reset.
    assign in_ready = rst_n & ((in_sel == SEL_B) ? ~w_b_full : ~w_a_full);
    assign w_accept = in_valid & in_ready;
    assign w_a_push = w_accept & (in_sel == SEL_A);
    assign w_b_push = w_accept & (in_sel == SEL_B);
    assign w_a_pop  = a_valid & a_ready;
    assign w_b_pop  = b_valid & b_ready;

    assign a_valid = ~w_a_empty;
    assign b_valid = ~w_b_empty;

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_a_push),
        .pop   (w_a_pop),
        .din   (in_data),
        .dout  (a_data),
        .full  (w_a_full),
        .empty (w_a_empty),
        .level (a_level)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_b_push),
        .pop   (w_b_pop),
        .din   (in_data),
        .dout  (b_data),
        .full  (w_b_full),
        .empty (w_b_empty),
        .level (b_level)
    );

endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb/tb_stream_demux_1x2.sv - scoreboard bench for stream_demux_1x2
module tb_stream_demux_1x2;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [1:0]       a_level;
    logic [1:0]       b_level;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];

    stream_demux_1x2 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_level  (a_level),
        .b_level  (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
    endtask

    // Inputs change just after posedge, so a negedge sample sees exactly what the next edge transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got %0h expected no word", a_data);
                end else begin
                    check("a_order", {16'h0, a_data}, {16'h0, qa.pop_front()});
                end
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got %0h expected no word", b_data);
                end else begin
                    check("b_order", {16'h0, b_data}, {16'h0, qb.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        a_ready = 1'b0; b_ready = 1'b0;

        // Reset state with in_valid asserted
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_a_valid",  a_valid, 0);
        check("rst_b_valid",  b_valid, 0);
        check("rst_a_level",  a_level, 0);
        check("rst_b_level",  b_level, 0);
        check("rst_a_data",   a_data, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Routing
        tick();
        a_ready = 1'b1; b_ready = 1'b1;
        drive(1'b0, 16'h1111);
        tick();
        check("route_a_valid", a_valid, 1);
        check("route_a_data",  a_data, 16'h1111);
        drive(1'b1, 16'h2222);
        tick();
        in_valid = 1'b0;
        check("route_b_valid", b_valid, 1);
        check("route_b_data",  b_data, 16'h2222);
        check("route_a_drain", a_valid, 0);
        tick();
        check("route_b_drain", b_valid, 0);

        // Fill and stall on A
        a_ready = 1'b0;
        drive(1'b0, 16'hA001); tick();
        drive(1'b0, 16'hA002); tick();
        in_valid = 1'b0;
        check("fill_a_level", a_level, 2);
        check("fill_ready_sel_a", in_ready, 0);
        in_sel = 1'b1; #1;
        check("fill_ready_sel_b", in_ready, 1);

        // Head-of-line blocking
        drive(1'b0, 16'hA003); #1;
        check("hol_ready", in_ready, 0);
        tick();
        check("hol_level_held", a_level, 2);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("hol_level_after_pop", a_level, 1);
        check("hol_ready_after_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("hol_level_refill", a_level, 2);
        check("hol_head", a_data, 16'hA002);
        a_ready = 1'b1;
        tick(); tick();
        check("hol_drained", a_level, 0);

        // Simultaneous push and pop at level 1
        a_ready = 1'b0;
        drive(1'b0, 16'hC001); tick();
        check("pp_level_before", a_level, 1);
        drive(1'b0, 16'hBEEF);
        a_ready = 1'b1;
        tick();
        in_valid = 1'b0; a_ready = 1'b0;
        check("pp_level", a_level, 1);
        check("pp_head",  a_data, 16'hBEEF);
        a_ready = 1'b1;
        tick();
        check("pp_drained", a_level, 0);

        // Reset mid-operation with both FIFOs full
        a_ready = 1'b0; b_ready = 1'b0;
        drive(1'b0, 16'hD001); tick();
        drive(1'b0, 16'hD002); tick();
        drive(1'b1, 16'hE001); tick();
        drive(1'b1, 16'hE002); tick();
        in_valid = 1'b0;
        check("mid_a_level", a_level, 2);
        check("mid_b_level", b_level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", a_valid, 0);
        check("mid_rst_b_valid", b_valid, 0);
        check("mid_rst_a_level", a_level, 0);
        check("mid_rst_b_level", b_level, 0);
        check("mid_rst_in_ready", in_ready, 0);
        qa.delete();
        qb.delete();
        tick();
        a_ready = 1'b1; b_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_a_valid", a_valid, 0);
            check("stale_b_valid", b_valid, 0);
        end

        // Traffic resumes normally after reset
        drive(1'b1, 16'h5A5A); tick();
        in_valid = 1'b0;
        check("resume_b_data", b_data, 16'h5A5A);
        tick(); tick();
        check("final_qa_empty", qa.size(), 0);
        check("final_qb_empty", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1x2.md
STREAM_DEMUX_1X2 -- requirements
Module: stream_demux_1x2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width in bits of the input and output streams.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: input payload.
REQ-005 The block SHALL have port in_sel, input, 1 bit: destination of the input word; 0 routes to port A, 1 routes to port B.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input word present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept the presented word.
REQ-008 The block SHALL have ports a_data (output, WIDTH bits), a_valid (output, 1 bit) and a_ready (input, 1 bit): the port A output stream.
REQ-009 The block SHALL have ports b_data (output, WIDTH bits), b_valid (output, 1 bit) and b_ready (input, 1 bit): the port B output stream.
REQ-010 The block SHALL have ports a_level and b_level, output, 2 bits each: current occupancy (0..2) of each port's buffer.

Function
REQ-011 Transfer rule SHALL be: an input transfer occurs on a clk edge where in_valid and in_ready are both 1; an output transfer occurs on a clk edge where x_valid and x_ready are both 1.
REQ-012 Each output port SHALL own a 2-entry FIFO; an accepted word SHALL be written to the FIFO of port A if in_sel=0, otherwise to the FIFO of port B.
REQ-013 in_ready SHALL equal "selected FIFO not full", decoded from in_sel and registered FIFO state only; in_ready SHALL have no combinational path from in_valid, a_ready or b_ready.
REQ-014 A full FIFO SHALL NOT accept a write, even when it is popped in the same cycle.
REQ-015 Latency SHALL be one cycle: a word accepted at edge N into an empty FIFO SHALL appear with x_valid=1 after edge N.
REQ-016 x_valid SHALL equal "FIFO non-empty"; x_data SHALL be the FIFO head.
REQ-017 While x_valid=1 and x_ready=0, x_data SHALL be held stable.
REQ-018 Order SHALL be preserved within each port; no ordering guarantee SHALL exist between ports.
REQ-019 Head-of-line blocking SHALL apply: a word destined for a full port stalls the input even when the other port has room; words SHALL NOT be reordered or dropped.
REQ-020 Simultaneous push and pop on a FIFO with level 1 SHALL leave the level at 1, with the new word becoming the head.
REQ-021 Simultaneous push and pop on a FIFO with level 2 SHALL NOT occur (REQ-014); the pop alone SHALL give level 1.
REQ-022 Pointer wrap-around SHALL use 1-bit read/write pointers; the level SHALL be tracked explicitly in 2 bits and SHALL never exceed 2 or underflow below 0.
REQ-023 x_data SHALL be don't-care for the bench while x_valid=0.
REQ-024 Changing in_sel or in_data while in_valid=1 and in_ready=0 SHALL be legal; only the values at the transfer edge SHALL count.

Reset
REQ-025 While rst_n=0, the block SHALL hold both FIFOs empty, both pointers and levels at 0, a_valid=b_valid=0, a_data=b_data=0 and in_ready=0.
REQ-026 Reset assertion mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-027 After rst_n rises, in_ready SHALL be 1 from the first cycle.

Structure
REQ-028 A shared package SHALL hold the constant DEMUX_DEPTH=2, the level width and the port-select encoding (SEL_A=0, SEL_B=1).
REQ-029 A single sub-module demux_fifo2 (parameter WIDTH; ports push, pop, din, dout, full, empty, level) SHALL be instantiated twice.
REQ-030 The top level SHALL contain only routing and handshake decode.

Verification
REQ-031 The bench SHALL cover reset: with rst_n=0 and in_valid=1 -> in_ready=0, a_valid=b_valid=0, a_level=b_level=0; after release -> in_ready=1.
REQ-032 The bench SHALL cover routing: push 0x1111 with sel=0, then 0x2222 with sel=1, with a_ready=b_ready=1 -> a_data=0x1111 one cycle after its accept, b_data=0x2222 one cycle after its accept.
REQ-033 The bench SHALL cover fill and stall: a_ready=0, push 0xA001, 0xA002 with sel=0 -> a_level=2, in_ready=0 for sel=0; presenting sel=1 -> in_ready=1.
REQ-034 The bench SHALL cover head-of-line: with A full, present 0xA003 sel=0; raise a_ready for 1 cycle -> 0xA001 popped, a_level=1 next cycle, 0xA003 accepted the following edge, A order 0xA002, 0xA003.
REQ-035 The bench SHALL cover simultaneous push and pop at level 1: a_ready=1 and a push of 0xBEEF on the same edge -> a_level stays 1, head becomes 0xBEEF.
REQ-036 The bench SHALL cover reset mid-operation: both levels at 2, pull rst_n low between edges -> a_valid=b_valid=0 immediately; after release no stale word is emitted.
